rgb_window_3x3: RTL

//  Converts a raster-order RGB pixel stream into 3x3 neighbourhood windows per channel.

---
 rtl/rgb_window_3x3_pkg.sv | 11 +
 rtl/rgb_window_3x3_line_buffer.sv | 20 ++
 rtl/rgb_window_3x3.sv | 83 ++++++++
 3 files changed

// File: rtl/rgb_window_3x3_pkg.sv
// rgb_window_3x3_pkg: pixel and window types shared by the windowing stage and its neighbours.
package rgb_window_3x3_pkg;
  localparam int PIX_W_DEF = 8;
  localparam int EDGE_THR = 32;
  typedef struct packed {
    logic [PIX_W_DEF-1:0] r;
    logic [PIX_W_DEF-1:0] g;
    logic [PIX_W_DEF-1:0] b;
  } rgb_t;
  typedef rgb_t [8:0] win3x3_t;
endpackage

// File: rtl/rgb_window_3x3_line_buffer.sv
// rgb_window_3x3_line_buffer: one-row pixel store, registered read, read-before-write, BRAM style.
module rgb_window_3x3_line_buffer #(
  parameter int DEPTH = 512,
  parameter int DW = 24,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/rgb_window_3x3.sv
// rgb_window_3x3: turns a raster RGB stream into per-channel 3x3 windows for interior centres.
// Line buffers are prefetched one pixel ahead so the window still lands one clock after acceptance.
module rgb_window_3x3
  import rgb_window_3x3_pkg::*;
#(
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_r,
  input  logic [PIX_W-1:0] in_g,
  input  logic [PIX_W-1:0] in_b,
  output logic [PIX_W-1:0] a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r, i_r,
  output logic [PIX_W-1:0] a_g, b_g, c_g, d_g, e_g, f_g, g_g, h_g, i_g,
  output logic [PIX_W-1:0] a_b, b_b, c_b, d_b, e_b, f_b, g_b, h_b, i_b,
  output logic             win_valid,
  output logic             win_eof,
  output logic             sof_err
);
  localparam int DW = 3 * PIX_W;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  logic [XW-1:0] x_q, x_d, x_cur;
  logic [YW-1:0] y_q, y_d, y_cur;
  logic [DW-1:0] pix, lb0_rd, lb1_rd;
  logic [2:0][DW-1:0] col;
  logic [2:0][2:0][DW-1:0] win_q;
  logic win_valid_q, win_eof_q, sof_err_q;
  assign pix = {in_r, in_g, in_b};
  assign x_cur = in_sof ? '0 : x_q;
  assign y_cur = in_sof ? '0 : y_q;
  always_comb begin
    x_d = (x_cur == X_LAST) ? '0 : x_cur + XW'(1);
    y_d = (x_cur != X_LAST) ? y_cur : (y_cur == Y_LAST) ? '0 : y_cur + YW'(1);
  end
  // read address is the next pixel's column, so data is ready when that pixel arrives
  rgb_window_3x3_line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb0 (
    .clk(clk), .we_i(in_valid), .waddr_i(x_cur), .wdata_i(pix),
    .re_i(in_valid), .raddr_i(x_d), .rdata_o(lb0_rd)
  );
  rgb_window_3x3_line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
    .clk(clk), .we_i(in_valid), .waddr_i(x_cur), .wdata_i(lb0_rd),
    .re_i(in_valid), .raddr_i(x_d), .rdata_o(lb1_rd)
  );
  assign col = {pix, lb0_rd, lb1_rd};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= '0;
      y_q         <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_eof_q   <= 1'b0;
      sof_err_q   <= 1'b0;
    end else begin
      win_valid_q <= in_valid && x_cur >= XW'(2) && y_cur >= YW'(2);
      win_eof_q   <= in_valid && x_cur == X_LAST && y_cur == Y_LAST;
      sof_err_q   <= in_valid && in_sof && (x_q != '0 || y_q != '0);
      if (in_valid) begin
        x_q <= x_d;
        y_q <= y_d;
        for (int r = 0; r < 3; r++) win_q[r] <= {col[r], win_q[r][2:1]};
      end
    end
  end
  assign {a_r, a_g, a_b} = win_q[0][0];
  assign {b_r, b_g, b_b} = win_q[0][1];
  assign {c_r, c_g, c_b} = win_q[0][2];
  assign {d_r, d_g, d_b} = win_q[1][0];
  assign {e_r, e_g, e_b} = win_q[1][1];
  assign {f_r, f_g, f_b} = win_q[1][2];
  assign {g_r, g_g, g_b} = win_q[2][0];
  assign {h_r, h_g, h_b} = win_q[2][1];
  assign {i_r, i_g, i_b} = win_q[2][2];
  assign win_valid = win_valid_q;
  assign win_eof   = win_eof_q;
  assign sof_err   = sof_err_q;
endmodule
